// File: rtl/iob_eth_noauto_write.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : iob_eth_noauto_write                                      |
// | Brief  : CSR write adapter; buffers CSR writes in a small FIFO and |
// |          drains them to the core over a wen/ready handshake.       |
// | Rev    : 1.0 - initial release                                     |
// +--------------------------------------------------------------------+
module iob_eth_noauto_write #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2
) (
    input  logic                       clk_i,
    input  logic                       cke_i,
    input  logic                       rst_i,
    input  logic                       valid_i,
    input  logic [DATA_W-1:0]          wdata_i,
    input  logic [DATA_W/8-1:0]        wstrb_i,
    output logic                       ready_o,
    input  logic                       clear_i,
    output logic                       int_wen_o,
    output logic [DATA_W-1:0]          int_wdata_o,
    output logic [DATA_W/8-1:0]        int_wstrb_o,
    input  logic                       int_ready_i,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic                       empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int SW = DATA_W / 8;
    localparam int EW = DATA_W + SW;

    logic [EW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [LW-1:0] r_level;

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic [EW-1:0] w_head;

    assign w_full  = (r_level == LW'(DEPTH));
    assign w_empty = (r_level == '0);

    // ready_o depends only on held state and clear_i, never on the core side
    assign ready_o = ~w_full & ~clear_i;
    assign w_push  = valid_i & ready_o & (|wstrb_i);
    assign w_pop   = ~w_empty & int_ready_i;

    always_ff @(posedge clk_i) begin
        if (cke_i) begin
            if (rst_i || clear_i) begin
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_level <= '0;
            end else begin
                if (w_push) begin
                    r_wptr <= r_wptr + AW'(1);
                end
                if (w_pop) begin
                    r_rptr <= r_rptr + AW'(1);
                end
                if (w_push && !w_pop) begin
                    r_level <= r_level + LW'(1);
                end else if (w_pop && !w_push) begin
                    r_level <= r_level - LW'(1);
                end
            end
        end
    end

    // Storage is not reset; entries are only visible through the level count
    always_ff @(posedge clk_i) begin
        if (cke_i && !rst_i && w_push) begin
            r_mem[r_wptr] <= {wdata_i, wstrb_i};
        end
    end

    assign w_head      = w_empty ? '0 : r_mem[r_rptr];
    assign int_wen_o   = ~w_empty;
    assign int_wdata_o = w_head[EW-1:SW];
    assign int_wstrb_o = w_head[SW-1:0];
    assign level_o     = r_level;
    assign empty_o     = w_empty;

endmodule
`default_nettype wire

// File: tb/tb_iob_eth_noauto_write.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : tb_iob_eth_noauto_write                                   |
// | Brief  : Self-checking bench with a queue-based reference model.   |
// | Rev    : 1.0 - initial release                                     |
// +--------------------------------------------------------------------+
module tb_iob_eth_noauto_write;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 2;
    localparam int SW     = DATA_W / 8;

    logic              clk_i = 1'b0;
    logic              cke_i;
    logic              rst_i;
    logic              valid_i;
    logic [DATA_W-1:0] wdata_i;
    logic [SW-1:0]     wstrb_i;
    logic              ready_o;
    logic              clear_i;
    logic              int_wen_o;
    logic [DATA_W-1:0] int_wdata_o;
    logic [SW-1:0]     int_wstrb_o;
    logic              int_ready_i;
    logic [$clog2(DEPTH):0] level_o;
    logic              empty_o;

    int tests  = 0;
    int failed = 0;
    int pops   = 0;
    bit chk_en = 1'b0;
    logic [DATA_W+SW-1:0] sb[$];

    iob_eth_noauto_write #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk_i       (clk_i),
        .cke_i       (cke_i),
        .rst_i       (rst_i),
        .valid_i     (valid_i),
        .wdata_i     (wdata_i),
        .wstrb_i     (wstrb_i),
        .ready_o     (ready_o),
        .clear_i     (clear_i),
        .int_wen_o   (int_wen_o),
        .int_wdata_o (int_wdata_o),
        .int_wstrb_o (int_wstrb_o),
        .int_ready_i (int_ready_i),
        .level_o     (level_o),
        .empty_o     (empty_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: compares outputs mid-cycle, then advances on the coming edge
    always @(negedge clk_i) begin
        if (chk_en) begin
            automatic bit exp_ready = (sb.size() < DEPTH) && !clear_i;
            automatic logic [DATA_W+SW-1:0] head = (sb.size() != 0) ? sb[0] : '0;
            check("ready_o",   ready_o, exp_ready);
            check("int_wen_o", int_wen_o, sb.size() != 0);
            check("level_o",   level_o, sb.size());
            check("empty_o",   empty_o, sb.size() == 0);
            check("int_wdata", int_wdata_o, head[DATA_W+SW-1:SW]);
            check("int_wstrb", int_wstrb_o, head[SW-1:0]);
            if (cke_i) begin
                if (rst_i || clear_i) begin
                    sb.delete();
                end else begin
                    if (int_ready_i && sb.size() != 0) begin
                        void'(sb.pop_front());
                        pops++;
                    end
                    if (valid_i && exp_ready && wstrb_i != '0)
                        sb.push_back({wdata_i, wstrb_i});
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wr(input logic v, input logic [DATA_W-1:0] d, input logic [SW-1:0] s);
        valid_i = v;
        wdata_i = d;
        wstrb_i = s;
    endtask

    initial begin
        cke_i = 1'b1; rst_i = 1'b1; clear_i = 1'b0; int_ready_i = 1'b0;
        wr(1'b0, '0, '0);
        cyc(); cyc();
        rst_i = 1'b0;
        chk_en = 1'b1;
        #1;
        check("rst_ready", ready_o, 1'b1);
        check("rst_empty", empty_o, 1'b1);
        check("rst_wdata", int_wdata_o, 32'h0);

        // Single write drained immediately
        int_ready_i = 1'b1;
        wr(1'b1, 32'hA5A5_0001, 4'hF);
        cyc();
        wr(1'b0, '0, '0);
        check("t1_wen",   int_wen_o, 1'b1);
        check("t1_wdata", int_wdata_o, 32'hA5A5_0001);
        cyc();
        check("t1_empty", empty_o, 1'b1);

        // Back-to-back writes into a stalled core
        int_ready_i = 1'b0;
        wr(1'b1, 32'h1, 4'hF); cyc();
        wr(1'b1, 32'h2, 4'hF); cyc();
        wr(1'b1, 32'h3, 4'hF); #1;
        check("t2_full_lvl",   level_o, 2);
        check("t2_full_ready", ready_o, 1'b0);
        cyc(); cyc();
        int_ready_i = 1'b1;
        cyc();
        check("t2_lvl_after_pop", level_o, 1);
        check("t2_head2", int_wdata_o, 32'h2);
        cyc();
        wr(1'b0, '0, '0);
        check("t2_head3", int_wdata_o, 32'h3);
        cyc(); cyc();

        // Single pop while full: no same-cycle push, level 2 -> 1 -> 2
        int_ready_i = 1'b0;
        wr(1'b1, 32'h4, 4'h1); cyc();
        wr(1'b1, 32'h5, 4'h2); cyc();
        wr(1'b1, 32'h6, 4'h4);
        int_ready_i = 1'b1;
        cyc();
        int_ready_i = 1'b0;
        check("t3_lvl1", level_o, 1);
        check("t3_ready", ready_o, 1'b1);
        cyc();
        wr(1'b0, '0, '0);
        check("t3_lvl2", level_o, 2);
        int_ready_i = 1'b1;
        cyc(); cyc(); cyc();

        // Null write
        wr(1'b1, 32'h77, 4'h0); #1;
        check("t4_ready", ready_o, 1'b1);
        cyc();
        wr(1'b0, '0, '0);
        check("t4_lvl", level_o, 0);
        check("t4_wen", int_wen_o, 1'b0);

        // Clear with a concurrent write
        int_ready_i = 1'b0;
        wr(1'b1, 32'h7, 4'hF); cyc();
        wr(1'b1, 32'h8, 4'hF); cyc();
        wr(1'b1, 32'h9, 4'hF);
        clear_i = 1'b1; int_ready_i = 1'b1; #1;
        check("t5_ready", ready_o, 1'b0);
        cyc();
        clear_i = 1'b0;
        wr(1'b0, '0, '0);
        check("t5_lvl", level_o, 0);
        check("t5_wen", int_wen_o, 1'b0);
        wr(1'b1, 32'hDEAD, 4'hF); cyc();
        wr(1'b0, '0, '0);
        check("t5_dead", int_wdata_o, 32'hDEAD);
        cyc();

        // Clock enable freeze
        int_ready_i = 1'b0;
        wr(1'b1, 32'h55, 4'h3); cyc();
        wr(1'b0, '0, '0);
        cke_i = 1'b0; int_ready_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            check("t6_lvl_hold", level_o, 1);
            check("t6_head_hold", int_wdata_o, 32'h55);
        end
        cke_i = 1'b1;
        cyc();
        check("t6_popped", level_o, 0);

        // Reset mid-drain
        int_ready_i = 1'b0;
        wr(1'b1, 32'hBEEF, 4'hF); cyc();
        wr(1'b0, '0, '0);
        rst_i = 1'b1; cyc();
        rst_i = 1'b0;
        check("t7_wen", int_wen_o, 1'b0);

        // Randomised traffic against the model
        for (int i = 0; i < 400; i++) begin
            wr(1'($urandom_range(0, 1)), $urandom,
               ($urandom_range(0, 5) == 0) ? 4'h0 : 4'($urandom_range(1, 15)));
            int_ready_i = 1'($urandom_range(0, 1));
            clear_i     = ($urandom_range(0, 19) == 0);
            cke_i       = ($urandom_range(0, 9) != 0);
            cyc();
        end
        wr(1'b0, '0, '0);
        clear_i = 1'b0; cke_i = 1'b1; int_ready_i = 1'b1;
        cyc(); cyc(); cyc();
        chk_en = 1'b0;
        check("pops_seen", pops > 20, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
`default_nettype wire
